tap_tempo_detector: RTL

Reverse direction of the BPM trigger path. It measures the interval between user taps on a button and reports the tempo those taps imply, in BPM. The input is a raw tap button. The output is a BPM value plus a valid strobe, for loading into the tempo setting or for display.

---
 rtl/tap_tempo_pkg.sv | 32 +++
 rtl/tap_tempo_detector_serial_divider_u32.sv | 79 +++++++
 rtl/tap_tempo_detector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tap_tempo_pkg.sv
// Shared types and constants for the tap tempo detector: FSM states, divider
// iteration count and the tempo/period constant calculation.
package tap_tempo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } tap_state_e;

    localparam int DIV_ITERS = 32;

    typedef struct packed {
        logic [31:0] dividend;
        logic [31:0] p_min;
        logic [31:0] p_max;
    } tempo_consts_t;

    // Periods are in clock cycles per beat: the slowest tempo gives the longest period.
    function automatic tempo_consts_t calc_tempo_consts(input longint unsigned clk_hz,
                                                        input longint unsigned min_bpm,
                                                        input longint unsigned max_bpm);
        longint unsigned dividend;
        tempo_consts_t   c;
        dividend   = 60 * clk_hz;
        c.dividend = dividend[31:0];
        c.p_min    = 32'(dividend / max_bpm);
        c.p_max    = 32'(dividend / min_bpm);
        return c;
    endfunction

endpackage

// File: rtl/tap_tempo_detector_serial_divider_u32.sv
// Restoring serial divider: one quotient bit per cycle, fixed 32 iterations after
// the load cycle. o_done pulses in the cycle the final quotient is first visible.
module serial_divider_u32
    import tap_tempo_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [32:0] trial;
    logic [32:0] diff;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        // Dividend bits shift out of the quotient register into the remainder MSB-first.
        trial  = {rem_q, quo_q[31]};
        diff   = trial - {1'b0, dvs_q};
        if (i_start && !busy_q) begin
            rem_d  = '0;
            quo_d  = i_dividend;
            dvs_d  = i_divisor;
            cnt_d  = 6'(DIV_ITERS);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_quotient = quo_q;

endmodule

// File: rtl/tap_tempo_detector.sv
// Tap tempo detector: debounced tap button -> tap interval -> BPM via serial divide.
// Optional TAP_TEMPO_AVG_EN smooths the period with a 3/4 + 1/4 running filter.
module tap_tempo_detector
    import tap_tempo_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 500_000,
    parameter int unsigned MIN_BPM      = 30,
    parameter int unsigned MAX_BPM      = 300,
    parameter int unsigned BPM_W        = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_tap,
    output logic             o_tap,
    output logic [BPM_W-1:0] o_bpm,
    output logic             o_valid,
    output logic             o_reject
);

    localparam tempo_consts_t TC = calc_tempo_consts(CLK_HZ, MIN_BPM, MAX_BPM);
    localparam int unsigned P_MAX = TC.p_max;
    localparam int CNT_W = $clog2(P_MAX + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] P_MIN_C = CNT_W'(TC.p_min);
    localparam logic [CNT_W-1:0] P_MAX_C = CNT_W'(TC.p_max);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_level_q, db_level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    tap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [BPM_W-1:0] bpm_q, bpm_d;
    logic             tap;
    logic             accept;
    logic             reject;
    logic             valid;
    logic [BPM_W-1:0] quot_bpm;
    logic [31:0]      div_divisor;
    logic             div_busy;
    logic             div_done;
    logic [31:0]      div_quot;

    // A level change is accepted on the DEBOUNCE_CYC-th consecutive differing sample.
    always_comb begin
        sync1_d    = i_btn_tap;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        tap        = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                tap        = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // The quotient always fits for in-range intervals; saturation only guards the impossible case.
    assign quot_bpm = (|div_quot[31:BPM_W]) ? '1 : div_quot[BPM_W-1:0];

    // The counter holds k in the k-th cycle after a tap, so it reads the interval directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bpm_d   = bpm_q;
        accept  = 1'b0;
        reject  = 1'b0;
        valid   = 1'b0;
        cnt_inc = (cnt_q == P_MAX_C) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (tap) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                if (tap) begin
                    cnt_d = CNT_ONE;
                    if (cnt_q < P_MIN_C) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = DIVIDE;
                    end
                end else if (cnt_q == P_MAX_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                cnt_d = cnt_inc;
                if (tap) begin
                    cnt_d = CNT_ONE;
                end
                // A tap landing on the completion cycle restarts the count without a reject pulse.
                if (div_done) begin
                    valid   = 1'b1;
                    bpm_d   = quot_bpm;
                    state_d = MEASURE;
                end else begin
                    reject = tap;
                    if (!div_busy) begin
                        state_d = MEASURE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef TAP_TEMPO_AVG_EN
    logic [CNT_W-1:0] filt_q, filt_d;
    logic             filt_vld_q, filt_vld_d;
    logic [CNT_W+1:0] filt_sum;
    logic [CNT_W-1:0] period_sel;

    always_comb begin
        filt_sum   = (CNT_W+2)'({filt_q, 1'b0}) + (CNT_W+2)'(filt_q) + (CNT_W+2)'(cnt_q);
        period_sel = filt_vld_q ? filt_sum[CNT_W+1:2] : cnt_q;
        filt_d     = filt_q;
        filt_vld_d = filt_vld_q;
        if (state_d == IDLE) begin
            filt_d     = '0;
            filt_vld_d = 1'b0;
        end else if (accept) begin
            filt_d     = period_sel;
            filt_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            filt_q     <= '0;
            filt_vld_q <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_vld_q <= filt_vld_d;
        end
    end

    assign div_divisor = {{(32-CNT_W){1'b0}}, period_sel};
`else
    assign div_divisor = {{(32-CNT_W){1'b0}}, cnt_q};
`endif

    serial_divider_u32 u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (accept),
        .i_dividend (TC.dividend),
        .i_divisor  (div_divisor),
        .o_busy     (div_busy),
        .o_done     (div_done),
        .o_quotient (div_quot)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bpm_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bpm_q      <= bpm_d;
        end
    end

    // o_bpm shows the new quotient in the same cycle as the o_valid pulse.
    assign o_tap    = tap;
    assign o_valid  = valid;
    assign o_reject = reject;
    assign o_bpm    = valid ? quot_bpm : bpm_q;

endmodule
